// File: rtl/lshift_deser_if.sv
// Parallel/serial bundle for the left-shift deserialiser.
//   master : the deserialiser side (drives par_out, par_valid, busy, overrun)
//   slave  : the source/consumer side (drives ser_in, ser_valid, start,
//            par_ready, ovr_clr)
interface lshift_deser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ser_in;
  logic             ser_valid;
  logic             start;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    input  ser_in,
    input  ser_valid,
    input  start,
    output par_out,
    output par_valid,
    input  par_ready,
    output busy,
    output overrun,
    input  ovr_clr
  );

  modport slave (
    output ser_in,
    output ser_valid,
    output start,
    input  par_out,
    input  par_valid,
    output par_ready,
    input  busy,
    input  overrun,
    output ovr_clr
  );
endinterface

// File: rtl/lshift_deser.sv
// Receive end of a left-shift serial stream. Bits arrive MSB-first and are
// assembled into a WIDTH-bit word, which is offered on a valid/ready
// holding register. A start strobe resynchronises the frame; a word that
// completes while the holding register is still occupied is dropped and
// flagged on the sticky overrun output.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - lshift_deser_if.master: ser_in/ser_valid/start in, par_out/
//          par_valid out, par_ready in, busy/overrun out, ovr_clr in
module lshift_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lshift_deser_if.master       bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             busy_q;
  logic             overrun_q, overrun_d;

  // Register after shifting the current serial bit in.
  logic [WIDTH-1:0] shifted_c;
  assign shifted_c = {sreg[WIDTH-2:0], bus.ser_in};

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_d;
      sreg        <= sreg_d;
      cnt         <= cnt_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      busy_q      <= (state_d == SHIFT);
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, shift/count and holding-register logic.
  always_comb begin
    state_d     = state;
    sreg_d      = sreg;
    cnt_d       = cnt;
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;

    // Consumer takes the held word; a completion below may refill it.
    if (par_valid_q && bus.par_ready) begin
      par_valid_d = 1'b0;
    end

    // Clear first so a same-edge drop below wins.
    if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end

    if (bus.start) begin
      // New frame from IDLE or resync from SHIFT: partial bits discarded.
      state_d = SHIFT;
      if (bus.ser_valid) begin
        sreg_d = {{(WIDTH-1){1'b0}}, bus.ser_in};
        cnt_d  = CW'(1);
      end else begin
        sreg_d = '0;
        cnt_d  = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // Serial bits outside a frame are ignored.
        end
        SHIFT: begin
          if (bus.ser_valid) begin
            sreg_d = shifted_c;
            if (cnt == CW'(WIDTH - 1)) begin
              cnt_d   = '0;
              state_d = IDLE;
              // Holding register is free if empty or being read this edge.
              if (!par_valid_q || bus.par_ready) begin
                par_out_d   = shifted_c;
                par_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_lshift_deser.sv
// Directed bench for lshift_deser: stimulus pushes expected words into a
// scoreboard queue; a monitor pops and compares on every handshake.
module tb_lshift_deser;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;

  lshift_deser_if #(.WIDTH(WIDTH)) bus ();

  lshift_deser #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.par_valid === 1'b1 && bus.par_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h expected=none at %0t", bus.par_out, $time);
      end else begin
        chk("sb_word", 32'(bus.par_out), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first n bits of w MSB-first, start on the first bit.
  // gap inserts an idle cycle between bits; rdy_last raises par_ready
  // only on the edge that samples the final bit.
  task automatic send_bits(input logic [7:0] w, input int n, input bit gap,
                           input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      bus.start     = (i == 0);
      bus.ser_valid = 1'b1;
      bus.ser_in    = w[7-i];
      if (rdy_last && i == n - 1) bus.par_ready = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.ser_valid = 1'b0;
      if (rdy_last && i == n - 1) bus.par_ready = 1'b0;
      if (gap && i < n - 1) begin
        bus.ser_in = ~bus.ser_in;
        tick();
        chk("gap_busy", 32'(bus.busy), 32'd1);
        chk("gap_no_valid", 32'(bus.par_valid), 32'd0);
      end
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.start     = 1'b0;
    bus.par_ready = 1'b0;
    bus.ovr_clr   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_par_valid", 32'(bus.par_valid), 32'd0);
    chk("rst_par_out", 32'(bus.par_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);

    // Idle serial bits without start are ignored.
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'b1;
    tick();
    bus.ser_valid = 1'b0;
    chk("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // Basic capture of 0x01 with consumer ready.
    bus.par_ready = 1'b1;
    sb_q.push_back(8'h01);
    send_bits(8'h01, 8, 1'b0, 1'b0);
    chk("basic_valid", 32'(bus.par_valid), 32'd1);
    chk("basic_out", 32'(bus.par_out), 32'h01);
    chk("basic_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("basic_valid_1cyc", 32'(bus.par_valid), 32'd0);
    drain("basic_drain");

    // Gapped 0xA5.
    sb_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b1, 1'b0);
    chk("gap_valid", 32'(bus.par_valid), 32'd1);
    chk("gap_out", 32'(bus.par_out), 32'hA5);
    drain("gap_drain");

    // Backpressure: 0x3C held, 0xC3 dropped.
    bus.par_ready = 1'b0;
    sb_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 1'b0, 1'b0);
    chk("bp_first_out", 32'(bus.par_out), 32'h3C);
    chk("bp_no_ovr_yet", 32'(bus.overrun), 32'd0);
    send_bits(8'hC3, 8, 1'b0, 1'b0);
    chk("bp_held_out", 32'(bus.par_out), 32'h3C);
    chk("bp_held_valid", 32'(bus.par_valid), 32'd1);
    chk("bp_overrun", 32'(bus.overrun), 32'd1);
    bus.par_ready = 1'b1;
    tick();
    bus.par_ready = 1'b0;
    chk("bp_xfer_valid", 32'(bus.par_valid), 32'd0);
    chk("bp_xfer_out_held", 32'(bus.par_out), 32'h3C);
    chk("bp_overrun_sticky", 32'(bus.overrun), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("bp_ovr_clr", 32'(bus.overrun), 32'd0);
    chk("bp_drain", 32'(sb_q.size()), 32'd0);

    // Accept on completion edge: 0x11 leaves as 0x22 arrives.
    sb_q.push_back(8'h11);
    send_bits(8'h11, 8, 1'b0, 1'b0);
    chk("acc_first_out", 32'(bus.par_out), 32'h11);
    sb_q.push_back(8'h22);
    send_bits(8'h22, 8, 1'b0, 1'b1);
    chk("acc_valid", 32'(bus.par_valid), 32'd1);
    chk("acc_out", 32'(bus.par_out), 32'h22);
    chk("acc_overrun", 32'(bus.overrun), 32'd0);
    chk("acc_popped", 32'(sb_q.size()), 32'd1);
    bus.par_ready = 1'b1;
    drain("acc_drain");

    // Resync: 5 bits of 0xFF abandoned by a new frame of 0x81.
    send_bits(8'hFF, 5, 1'b0, 1'b0);
    chk("resync_busy", 32'(bus.busy), 32'd1);
    chk("resync_no_valid", 32'(bus.par_valid), 32'd0);
    sb_q.push_back(8'h81);
    send_bits(8'h81, 8, 1'b0, 1'b0);
    chk("resync_out", 32'(bus.par_out), 32'h81);
    chk("resync_overrun", 32'(bus.overrun), 32'd0);
    drain("resync_drain");

    // Reset mid-frame.
    send_bits(8'hF0, 4, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", 32'(bus.par_valid), 32'd0);
    chk("rstmid_out", 32'(bus.par_out), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    // Remaining bits of the aborted frame must not complete a word.
    for (int i = 0; i < 8; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = 1'b1;
      tick();
    end
    bus.ser_valid = 1'b0;
    chk("rstmid_no_word", 32'(bus.par_valid), 32'd0);

    // Reset with a word pending: it is lost.
    bus.par_ready = 1'b0;
    send_bits(8'h77, 8, 1'b0, 1'b0);
    chk("rstpend_valid_before", 32'(bus.par_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstpend_valid", 32'(bus.par_valid), 32'd0);
    chk("rstpend_out", 32'(bus.par_out), 32'd0);
    chk("rstpend_busy", 32'(bus.busy), 32'd0);

    // Clean frame after reset.
    bus.par_ready = 1'b1;
    sb_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 1'b0, 1'b0);
    chk("post_rst_out", 32'(bus.par_out), 32'h5A);
    chk("post_rst_valid", 32'(bus.par_valid), 32'd1);
    drain("post_rst_drain");
    tick();
    chk("final_overrun", 32'(bus.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lshift_deser.md
Name: lshift_deser

Overview:
- Receive end of the left-shift serial stream: collects bits MSB-first (bit 7 first, as a left shift register emits them) into a WIDTH-bit word.
- Presents each completed word on a valid/ready parallel interface.
- Sits between a serial source (a left-shift transmitter driving its op MSB) and a byte consumer.
- Detects frame resync and output overrun.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
ser_in  input  1  serial data bit, MSB-first
ser_valid  input  1  ser_in is sampled on this edge
start  input  1  frame-start strobe; aborts any partial word and begins a new frame
par_out  output  WIDTH  completed word; stable while par_valid=1
par_valid  output  1  par_out holds an unconsumed word
par_ready  input  1  consumer accepts par_out this edge
busy  output  1  1 while in SHIFT state
overrun  output  1  sticky; a completed word was dropped
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (rst=1 at edge): state=IDLE, shift reg=0, bit count=0, par_out=0, par_valid=0, busy=0, overrun=0. Overrides all other inputs.
- Bit counter: $clog2(WIDTH+1) bits. Shift: sreg <= {sreg[WIDTH-2:0], ser_in}.
- IDLE:
  - ser_valid without start is ignored.
  - start=1 -> SHIFT. If ser_valid is also 1 on that edge, ser_in is bit 0 of the frame (count=1). Otherwise count=0.
- SHIFT:
  - Each ser_valid edge shifts one bit in and increments count.
  - Gaps with ser_valid=0 hold state.
  - On the edge that samples bit WIDTH (count reaches WIDTH), the word completes, count clears, and state returns to IDLE.
  - start in SHIFT: discards partial bits and restarts the frame, with the same ser_valid rule as in IDLE. No word is emitted and overrun is unaffected.
- Word completion at edge N:
  - If the holding register is free (par_valid=0, or par_valid=1 and par_ready=1 at edge N), then after edge N par_out=new word and par_valid=1.
  - Otherwise the new word is dropped, par_out/par_valid are unchanged, and overrun<=1.
- Latency: par_valid rises in the cycle after the edge that samples the last bit (registered output; 1-edge latency from the last bit).
- Handshake:
  - A transfer occurs on an edge where par_valid=1 and par_ready=1. par_valid then falls, unless a word completes on the same edge, in which case it stays 1 with the new par_out.
  - par_ready while par_valid=0 has no effect.
  - par_out is held after a transfer; its value is don't-care while par_valid=0, but the implementation holds it.
- Overrun:
  - Set only by a dropped word. Cleared by ovr_clr or rst.
  - Set and ovr_clr on the same edge: set wins.
- busy = (state==SHIFT).
- Reset mid-frame: partial bits are lost, no word is emitted, and a pending par_valid is cleared.

Test Plan:
- Basic capture: rst for 2 clks; start+ser_valid with bits 0,0,0,0,0,0,0,1 on 8 consecutive edges, par_ready=1 -> par_out=0x01, par_valid=1 for exactly 1 cycle, the cycle after the 8th bit; busy=0 after.
- Gapped input: send 0xA5 (1,0,1,0,0,1,0,1) with ser_valid low every other cycle -> par_out=0xA5 after the 8th valid bit; no change during gaps; count unaffected by gaps.
- Backpressure/overrun: par_ready=0; send 0x3C then 0xC3 -> par_out stays 0x3C, par_valid stays 1, overrun=1. Raise par_ready -> one transfer of 0x3C. Pulse ovr_clr -> overrun=0.
- Accept on completion edge: hold 0x11 valid; assert par_ready exactly on the edge sampling the last bit of 0x22 -> par_valid stays 1, par_out=0x22, overrun=0.
- Resync: send 5 bits of 0xFF, then start+ser_valid with bits of 0x81 -> only 0x81 is emitted; no 0xFF-derived word; overrun=0.
- Reset mid-frame: after 4 bits of 0xF0, and again with par_valid=1 pending, assert rst for 1 clk -> par_valid=0, par_out=0, busy=0. A following clean frame of 0x5A is captured correctly.
